// File: rtl/uart_rx_fifo_if.sv
// Receive FIFO bus: producer strobe from uart_rx, consumer valid/ready, status and overflow control.
// The slave modport is the FIFO side; the master modport is the receiver/consumer side.
interface uart_rx_fifo_if #(
    parameter int unsigned DEPTH = 16
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_frame_err;
    logic [7:0]  rd_data;
    logic        rd_err;
    logic        rd_valid;
    logic        rd_ready;
    logic [AW:0] level;
    logic        almost_full;
    logic        overflow;
    logic        ovf_clr;
    logic [7:0]  drop_count;

    modport master (
        output rx_data, rx_valid, rx_frame_err, rd_ready, ovf_clr,
        input  rd_data, rd_err, rd_valid, level, almost_full, overflow, drop_count
    );

    modport slave (
        input  rx_data, rx_valid, rx_frame_err, rd_ready, ovf_clr,
        output rd_data, rd_err, rd_valid, level, almost_full, overflow, drop_count
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte FIFO behind uart_rx: stores {frame_err, data}, reports
// occupancy, and keeps a sticky overflow flag plus a saturating count of bytes lost to a full FIFO.
module uart_rx_fifo #(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned ALMOST_FULL = 12,
    parameter bit          DROP_ERR    = 1'b0
) (
    input logic           rx_clk,
    input logic           rst_n,
    uart_rx_fifo_if.slave bus
);
    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] LvlFull = (AW+1)'(DEPTH);
    localparam logic [AW:0] LvlAf   = (AW+1)'(ALMOST_FULL);

    logic [8:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;
    logic          full, pop, want, push, drop;

    always_comb begin
        full = (level_q == LvlFull);
        pop  = (level_q != '0) && bus.rd_ready;
        want = bus.rx_valid && !(DROP_ERR && bus.rx_frame_err);
        // A full FIFO still accepts a byte when the head leaves on the same edge.
        push = want && (!full || pop);
        drop = want && full && !pop;
    end

    always_comb begin
        level_d = level_q;
        unique case ({push, pop})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    always_comb begin
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            overflow_d = 1'b1;
            // A clear coinciding with a drop still records that drop.
            if (bus.ovf_clr) begin
                drop_cnt_d = 8'd1;
            end else if (drop_cnt_q != 8'hFF) begin
                drop_cnt_d = drop_cnt_q + 8'd1;
            end
        end else if (bus.ovf_clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q    <= level_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    // Storage carries no reset; the pointers alone define what is valid.
    always_ff @(posedge rx_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {bus.rx_frame_err, bus.rx_data};
        end
    end

    assign bus.rd_data     = mem_q[rd_ptr_q][7:0];
    assign bus.rd_err      = mem_q[rd_ptr_q][8];
    assign bus.rd_valid    = (level_q != '0);
    assign bus.level       = level_q;
    assign bus.almost_full = (level_q >= LvlAf);
    assign bus.overflow    = overflow_q;
    assign bus.drop_count  = drop_cnt_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus randomized traffic against a
// queue-based reference model of the FIFO, overflow flag and drop counter.
module tb_uart_rx_fifo;
    localparam int unsigned Depth      = 16;
    localparam int unsigned AlmostFull = 12;

    logic clk = 1'b0;
    logic rst_n;
    int   nvec = 0;
    int   nerr = 0;

    logic [8:0] mq[$];
    bit         m_ovf;
    int         m_dc;

    uart_rx_fifo_if #(.DEPTH(Depth)) bus ();
    uart_rx_fifo_if #(.DEPTH(Depth)) bus_d ();

    uart_rx_fifo #(.DEPTH(Depth), .ALMOST_FULL(AlmostFull), .DROP_ERR(1'b0)) dut (
        .rx_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    uart_rx_fifo #(.DEPTH(Depth), .ALMOST_FULL(AlmostFull), .DROP_ERR(1'b1)) dut_d (
        .rx_clk (clk),
        .rst_n  (rst_n),
        .bus    (bus_d)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        mq.delete();
        m_ovf = 1'b0;
        m_dc  = 0;
    endtask

    // Reference for the DROP_ERR=0 instance, evaluated against the pre-edge state.
    task automatic model_edge(input bit v, input bit e, input logic [7:0] d, input bit rdy,
                              input bit clr);
        bit pop;
        bit full;
        pop  = (mq.size() != 0) && rdy;
        full = (mq.size() == Depth);
        if (pop) void'(mq.pop_front());
        if (v && (!full || pop)) mq.push_back({e, d});
        if (v && full && !pop) begin
            m_ovf = 1'b1;
            m_dc  = clr ? 1 : ((m_dc < 255) ? m_dc + 1 : 255);
        end else if (clr) begin
            m_ovf = 1'b0;
            m_dc  = 0;
        end
    endtask

    // Drive one cycle of inputs to the main DUT; returns 1 time unit after the edge.
    task automatic cycle(input bit v, input bit e, input logic [7:0] d, input bit rdy,
                         input bit clr);
        bus.rx_valid     = v;
        bus.rx_frame_err = e;
        bus.rx_data      = d;
        bus.rd_ready     = rdy;
        bus.ovf_clr      = clr;
        @(posedge clk);
        model_edge(v, e, d, rdy, clr);
        #1;
        bus.rx_valid = 1'b0;
        bus.rd_ready = 1'b0;
        bus.ovf_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nvec++;
        if (bus.rd_valid !== 1'b0) begin
            nerr++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid);
        end
        nvec++;
        if (bus.level !== 5'd0) begin
            nerr++; $display("FAIL reset_level: got %0d want 0", bus.level);
        end
        nvec++;
        if (bus.almost_full !== 1'b0 || bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            nerr++;
            $display("FAIL reset_flags: got af=%b ovf=%b dc=%0d want 0 0 0",
                     bus.almost_full, bus.overflow, bus.drop_count);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single();
        cycle(1'b1, 1'b0, 8'hE3, 1'b0, 1'b0);
        nvec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'hE3 || bus.rd_err !== 1'b0 ||
            bus.level !== 5'd1) begin
            nerr++;
            $display("FAIL single_push: got v=%b d=%h e=%b lvl=%0d want 1 e3 0 1",
                     bus.rd_valid, bus.rd_data, bus.rd_err, bus.level);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        nvec++;
        if (bus.rd_valid !== 1'b0 || bus.level !== 5'd0) begin
            nerr++;
            $display("FAIL single_pop: got v=%b lvl=%0d want 0 0", bus.rd_valid, bus.level);
        end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
            nvec++;
            if (bus.level !== 5'(i + 1) || bus.almost_full !== (i + 1 >= 12)) begin
                nerr++;
                $display("FAIL fill_level: got lvl=%0d af=%b want %0d %b",
                         bus.level, bus.almost_full, i + 1, (i + 1 >= 12));
            end
        end
        cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'hBB, 1'b0, 1'b0);
        nvec++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd2 || bus.level !== 5'd16) begin
            nerr++;
            $display("FAIL fill_overflow: got ovf=%b dc=%0d lvl=%0d want 1 2 16",
                     bus.overflow, bus.drop_count, bus.level);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'(i)) begin
                nerr++;
                $display("FAIL fill_drain: got v=%b d=%h want 1 %h", bus.rd_valid, bus.rd_data,
                         8'(i));
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        nvec++;
        if (bus.rd_valid !== 1'b0) begin
            nerr++; $display("FAIL fill_empty: got v=%b want 0", bus.rd_valid);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        nvec++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            nerr++;
            $display("FAIL fill_clear: got ovf=%b dc=%0d want 0 0", bus.overflow, bus.drop_count);
        end
    endtask

    task automatic test_full_pushpop();
        logic [7:0] want_d;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'h80 + 8'(i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h55, 1'b1, 1'b0);
        nvec++;
        if (bus.level !== 5'd16 || bus.overflow !== 1'b0) begin
            nerr++;
            $display("FAIL full_pushpop: got lvl=%0d ovf=%b want 16 0", bus.level, bus.overflow);
        end
        for (int j = 0; j < 16; j++) begin
            want_d = (j < 15) ? 8'h81 + 8'(j) : 8'h55;
            nvec++;
            if (bus.rd_data !== want_d) begin
                nerr++; $display("FAIL full_drain: got %h want %h", bus.rd_data, want_d);
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        for (int k = 0; k < 42; k++) begin
            nvec++;
            if ({bus.rd_err, bus.rd_data} !== mq[0] || bus.level !== 5'(mq.size())) begin
                nerr++;
                $display("FAIL wrap_order: got %h lvl=%0d want %h lvl=%0d",
                         {bus.rd_err, bus.rd_data}, bus.level, mq[0], mq.size());
            end
            cycle(k < 40, 1'b0, 8'($urandom), 1'b1, 1'b0);
        end
    endtask

    task automatic test_frame_err();
        bus_d.rx_valid = 1'b1; bus_d.rx_frame_err = 1'b1; bus_d.rx_data = 8'h7E;
        cycle(1'b1, 1'b1, 8'h7E, 1'b0, 1'b0);
        bus_d.rx_valid = 1'b0;
        nvec++;
        if (bus.rd_err !== 1'b1 || bus.rd_data !== 8'h7E || bus.level !== 5'd1) begin
            nerr++;
            $display("FAIL ferr_keep: got e=%b d=%h lvl=%0d want 1 7e 1",
                     bus.rd_err, bus.rd_data, bus.level);
        end
        nvec++;
        if (bus_d.rd_valid !== 1'b0 || bus_d.level !== 5'd0 || bus_d.overflow !== 1'b0) begin
            nerr++;
            $display("FAIL ferr_drop: got v=%b lvl=%0d ovf=%b want 0 0 0",
                     bus_d.rd_valid, bus_d.level, bus_d.overflow);
        end
        bus_d.rx_valid = 1'b1; bus_d.rx_frame_err = 1'b0; bus_d.rx_data = 8'h11;
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        bus_d.rx_valid = 1'b0;
        nvec++;
        if (bus_d.rd_valid !== 1'b1 || bus_d.rd_data !== 8'h11 || bus_d.rd_err !== 1'b0) begin
            nerr++;
            $display("FAIL ferr_good: got v=%b d=%h e=%b want 1 11 0",
                     bus_d.rd_valid, bus_d.rd_data, bus_d.rd_err);
        end
        bus_d.rd_ready = 1'b1;
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        bus_d.rd_ready = 1'b0;
        nvec++;
        if (bus.rd_valid !== 1'b0 || bus_d.rd_valid !== 1'b0) begin
            nerr++;
            $display("FAIL ferr_pop: got v=%b vd=%b want 0 0", bus.rd_valid, bus_d.rd_valid);
        end
    endtask

    task automatic test_drops();
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b1, 1'b0, 8'($urandom), 1'b0, 1'b0);
        nvec++;
        if (bus.drop_count !== 8'd255 || bus.overflow !== 1'b1 || bus.level !== 5'd16) begin
            nerr++;
            $display("FAIL drop_sat: got dc=%0d ovf=%b lvl=%0d want 255 1 16",
                     bus.drop_count, bus.overflow, bus.level);
        end
        cycle(1'b1, 1'b0, 8'h99, 1'b0, 1'b1);
        nvec++;
        if (bus.overflow !== 1'b1 || bus.drop_count !== 8'd1) begin
            nerr++;
            $display("FAIL drop_clr_same: got ovf=%b dc=%0d want 1 1", bus.overflow,
                     bus.drop_count);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        nvec++;
        if (bus.overflow !== 1'b0 || bus.drop_count !== 8'd0) begin
            nerr++;
            $display("FAIL drop_clr: got ovf=%b dc=%0d want 0 0", bus.overflow, bus.drop_count);
        end
        for (int i = 0; i < 16; i++) begin
            nvec++;
            if ({bus.rd_err, bus.rd_data} !== mq[0]) begin
                nerr++;
                $display("FAIL drop_drain: got %h want %h", {bus.rd_err, bus.rd_data}, mq[0]);
            end
            cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0, 1'b0);
        nvec++;
        if (bus.level !== 5'd5) begin
            nerr++; $display("FAIL arst_pre: got lvl=%0d want 5", bus.level);
        end
        #2;
        rst_n = 1'b0;
        #1;
        nvec++;
        if (bus.rd_valid !== 1'b0 || bus.level !== 5'd0) begin
            nerr++;
            $display("FAIL arst_now: got v=%b lvl=%0d want 0 0", bus.rd_valid, bus.level);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        nvec++;
        if (bus.rd_valid !== 1'b1 || bus.rd_data !== 8'h3C || bus.level !== 5'd1) begin
            nerr++;
            $display("FAIL arst_first: got v=%b d=%h lvl=%0d want 1 3c 1",
                     bus.rd_valid, bus.rd_data, bus.level);
        end
        cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        bit v;
        bit rdy;
        bit fill_phase;
        for (int i = 0; i < 800; i++) begin
            fill_phase = ((i / 100) % 2) == 0;
            v   = $urandom_range(0, 99) < (fill_phase ? 85 : 30);
            rdy = $urandom_range(0, 99) < (fill_phase ? 30 : 85);
            cycle(v, 1'($urandom), 8'($urandom), rdy, $urandom_range(0, 24) == 0);
            nvec++;
            if (bus.rd_valid !== (mq.size() != 0) || bus.level !== 5'(mq.size()) ||
                bus.almost_full !== (mq.size() >= AlmostFull)) begin
                nerr++;
                $display("FAIL rand_status: got v=%b lvl=%0d af=%b want lvl=%0d",
                         bus.rd_valid, bus.level, bus.almost_full, mq.size());
            end
            nvec++;
            if (bus.overflow !== m_ovf || bus.drop_count !== 8'(m_dc)) begin
                nerr++;
                $display("FAIL rand_ovf: got ovf=%b dc=%0d want %b %0d",
                         bus.overflow, bus.drop_count, m_ovf, m_dc);
            end
            if (mq.size() != 0) begin
                nvec++;
                if ({bus.rd_err, bus.rd_data} !== mq[0]) begin
                    nerr++;
                    $display("FAIL rand_head: got %h want %h", {bus.rd_err, bus.rd_data}, mq[0]);
                end
            end
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_frame_err = 1'b0;
        bus.rx_data      = 8'h00;
        bus.rd_ready     = 1'b0;
        bus.ovf_clr      = 1'b0;
        bus_d.rx_valid     = 1'b0;
        bus_d.rx_frame_err = 1'b0;
        bus_d.rx_data      = 8'h00;
        bus_d.rd_ready     = 1'b0;
        bus_d.ovf_clr      = 1'b0;
        model_reset();
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_pushpop();
        test_frame_err();
        test_drops();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer directly downstream of `uart_rx`. It captures each completed byte from the receiver, together with that byte's frame-error tag, into a first-word-fall-through FIFO. It presents the bytes to the consumer over a valid/ready interface and reports occupancy and overflow. It runs in the receiver's clock domain, so no synchronisers are needed between `uart_rx` and this block.

## Interface

Parameters:
- `DEPTH`, 16: number of entries. Must be a power of two, at least 2. Pointer width AW = $clog2(DEPTH).
- `ALMOST_FULL`, 12: occupancy threshold for `almost_full`. Legal range 1..DEPTH.
- `DROP_ERR`, 0: when 1, bytes received with a frame error are discarded and never stored.

Ports:
- `rx_clk`, in, 1: sole clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx_data`, in, 8: received byte from `uart_rx`. Qualified by `rx_valid`.
- `rx_valid`, in, 1: one-cycle strobe marking a completed byte.
- `rx_frame_err`, in, 1: stop bit was sampled low for the current byte. Qualified by `rx_valid`.
- `rd_data`, out, 8: byte at the FIFO head.
- `rd_err`, out, 1: frame-error tag of the head entry.
- `rd_valid`, out, 1: FIFO is non-empty.
- `rd_ready`, in, 1: consumer accepts the head entry. A pop occurs when `rd_valid && rd_ready`.
- `level`, out, AW+1: current occupancy, 0..DEPTH.
- `almost_full`, out, 1: `level >= ALMOST_FULL`.
- `overflow`, out, 1: sticky flag, set when a byte is dropped for lack of space.
- `ovf_clr`, in, 1: synchronous clear of `overflow` and `drop_count`.
- `drop_count`, out, 8: count of bytes dropped for lack of space. Saturates at 255.

## Operation

Storage:
- DEPTH x 9-bit register array. Each entry is {err, data}.
- Write pointer `wr_ptr` and read pointer `rd_ptr`, each AW bits. Both wrap modulo DEPTH.
- Occupancy counter `level`, AW+1 bits.
- Full is `level == DEPTH`. Empty is `level == 0`.

Events evaluated each cycle:
- `pop` = `rd_valid && rd_ready`.
- `want` = `rx_valid && !(DROP_ERR && rx_frame_err)`.
- `push` = `want && (!full || pop)`. A push while full is accepted when a pop occurs in the same cycle.
- `drop` = `want && full && !pop`.

Update rules:
- On push: `mem[wr_ptr] <= {rx_frame_err, rx_data}`, then `wr_ptr` increments.
- On pop: `rd_ptr` increments.
- `level` increments on push only, decrements on pop only, and holds when both or neither occur.
- When the FIFO is empty, `rd_valid` is 0, so no pop is possible. A push into an empty FIFO is a push only.
- Bytes discarded under `DROP_ERR` do not affect `overflow` or `drop_count`.

Outputs:
- `rd_data` and `rd_err` are a combinational read of `mem[rd_ptr]`. Their value is don't-care while `rd_valid` = 0.
- `rd_valid`, `almost_full` and `level` derive from the registered `level`, with no combinational path from `rx_valid`.

Overflow handling:
- A drop sets `overflow` <= 1.
- A drop increments `drop_count`, saturating at 255.
- `ovf_clr` clears both. If a drop and `ovf_clr` occur in the same cycle, the result is `overflow` = 1 and `drop_count` = 1.

Reset:
- Asserting `rst_n` low at any time, including mid-stream, immediately sets `wr_ptr`, `rd_ptr`, `level`, `overflow` and `drop_count` to 0.
- Stored data is discarded and array contents need not be reset.
- While reset is asserted: `rd_valid` = 0, `almost_full` = 0, `level` = 0, `overflow` = 0, `drop_count` = 0, and `rd_data`/`rd_err` are don't-care.

## Timing

- Write-to-read latency is 1 cycle. A byte pushed at edge N gives `rd_valid` = 1 and `rd_data` = that byte in the cycle following edge N.
- Pop is registered. After an accepting edge, the next entry is presented in the following cycle.
- The block sustains back-to-back pushes and pops every cycle. It is not limited to the UART byte rate.
- `level`, `almost_full`, `overflow` and `drop_count` update on the same edge as the event that changes them.
- `rx_valid` may be high on consecutive cycles and each cycle is a separate byte. This never happens from `uart_rx`, but the FIFO must handle it.
- `rd_ready` may be held high continuously. `rd_valid` does not depend on `rd_ready`.

## Test plan

- Reset, then push 0xE3 with `rx_frame_err` = 0 and `rd_ready` = 0. Required: the next cycle shows `rd_valid` = 1, `rd_data` = 0xE3, `rd_err` = 0, `level` = 1. Then pulse `rd_ready` for one cycle. Required: `rd_valid` = 0, `level` = 0.
- With DEPTH = 16, push 0x00..0x0F. Required: `level` = 16, `almost_full` = 1 from `level` = 12 onward. Push 0xAA, 0xBB. Required: `overflow` = 1, `drop_count` = 2. Drain. Required: output is 0x00..0x0F in order with no 0xAA or 0xBB.
- Fill to 16, then push 0x55 in the same cycle as a pop. Required: `level` stays 16, no overflow, and 0x55 is the last byte drained. Then run 40 push/pop pairs to exercise pointer wrap. Required: data order preserved.
- Push 0x7E with `rx_frame_err` = 1. With `DROP_ERR` = 0, required: `rd_err` = 1 and `rd_data` = 0x7E. With `DROP_ERR` = 1, required: `rd_valid` stays 0, `level` = 0, `overflow` = 0.
- Force 300 drops. Required: `drop_count` = 255. Assert `ovf_clr` in the same cycle as a drop. Required: `overflow` = 1, `drop_count` = 1. Assert `ovf_clr` alone. Required: both clear.
- With `level` = 5, assert `rst_n` low between clock edges. Required: `rd_valid` = 0 and `level` = 0 immediately. After release, push 0x3C. Required: 0x3C is the first byte read.
